// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate sequencer.
//   - one-bit shift op encodings used on in_op / op_q
//   - controller FSM state encoding
package shift_pkg;

    localparam logic [1:0] SH_LSR = 2'b00;  // logical right, MSB filled with 0
    localparam logic [1:0] SH_LSL = 2'b01;  // logical left, LSB filled with 0
    localparam logic [1:0] SH_ROR = 2'b10;  // rotate right, LSB wraps to MSB
    localparam logic [1:0] SH_ROL = 2'b11;  // rotate left, MSB wraps to LSB

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_seq_ctrl_shifter.sv
// shifter: purely combinational one-bit shift/rotate datapath.
// Ports:
//   op     in  OPSIZE  shift op (SH_LSR/SH_LSL/SH_ROR/SH_ROL)
//   data_b in  DSIZE   operand before the step
//   data_a out DSIZE   operand after one step
module shifter
    import shift_pkg::*;
#(
    parameter int OPSIZE = 2,
    parameter int DSIZE  = 16
) (
    input  logic [OPSIZE-1:0] op,
    input  logic [DSIZE-1:0]  data_b,
    output logic [DSIZE-1:0]  data_a
);

    always_comb begin
        data_a = data_b;
        case (op[1:0])
            SH_LSR: data_a = {1'b0, data_b[DSIZE-1:1]};
            SH_LSL: data_a = {data_b[DSIZE-2:0], 1'b0};
            SH_ROR: data_a = {data_b[0], data_b[DSIZE-1:1]};
            SH_ROL: data_a = {data_b[DSIZE-2:0], data_b[DSIZE-1]};
            default: data_a = data_b;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle shift/rotate sequencer. Accepts one request,
// applies the one-bit shifter once per clock for in_amt steps, then holds
// the result until the consumer takes it.
//
// state | meaning
// IDLE  | ready for a request (in_ready=1)
// SHIFT | stepping data_q through the shifter, cnt_q steps left
// DONE  | result valid on out_data, waiting for out_ready
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     request handshake; in_data, in_op, in_amt payload
//   out_valid/out_ready   result handshake; out_data result (= data_q)
//   busy                  high in SHIFT or DONE
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int DSIZE  = 16,
    parameter int OPSIZE = 2,
    parameter int ASIZE  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DSIZE-1:0]  in_data,
    input  logic [OPSIZE-1:0] in_op,
    input  logic [ASIZE-1:0]  in_amt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DSIZE-1:0]  out_data,
    output logic              busy
);

    state_e              state_q, state_d;
    logic [DSIZE-1:0]    data_q, data_d;
    logic [OPSIZE-1:0]   op_q, op_d;
    logic [ASIZE-1:0]    cnt_q, cnt_d;
    logic [DSIZE-1:0]    shift_res;

    shifter #(
        .OPSIZE (OPSIZE),
        .DSIZE  (DSIZE)
    ) u_shifter (
        .op     (op_q),
        .data_b (data_q),
        .data_a (shift_res)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    op_d    = in_op;
                    cnt_d   = in_amt;
                    state_d = (in_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // SHIFT is only entered with cnt_q >= 1, so this never wraps.
                data_d = shift_res;
                cnt_d  = cnt_q - ASIZE'(1);
                if (cnt_q == ASIZE'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs decode registered state only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SHIFT) || (state_q == DONE);
    assign out_data  = data_q;

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Multi-cycle shift/rotate sequencer built around the single-bit `shifter` datapath. It accepts one request (operand, shift op, shift amount) over a valid/ready handshake. It applies the one-bit shifter to the held operand once per clock for the requested number of steps. It then presents the result on an output valid/ready handshake. It sits between the ALU issue logic and the writeback path, and is the only owner of its `shifter` instance.

## Interface
- `DSIZE`, 16, operand width in bits (≥ 2)
- `OPSIZE`, 2, shift-op code width
- `ASIZE`, 4, shift-amount width; must equal clog2(`DSIZE`)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `in_valid`  in  1  request present
- `in_ready`  out  1  block can accept a request
- `in_data`  in  DSIZE  operand
- `in_op`  in  OPSIZE  00 logical right, 01 logical left, 10 rotate right, 11 rotate left
- `in_amt`  in  ASIZE  number of one-bit steps, 0..DSIZE-1
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer takes result
- `out_data`  out  DSIZE  shifted result
- `busy`  out  1  high in SHIFT or DONE

## Operation
- Registers:
  - `data_q` (DSIZE)
  - `op_q` (OPSIZE)
  - `cnt_q` (ASIZE)
  - `state_q`
- FSM states:
  - IDLE
  - SHIFT
  - DONE
- Reset values:
  - state IDLE
  - `data_q` 0, `op_q` 0, `cnt_q` 0
  - `out_valid` 0, `out_data` 0, `busy` 0
  - `in_ready` 1 (it is `state_q==IDLE`)
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch `in_data`→`data_q`, `in_op`→`op_q`, `in_amt`→`cnt_q`.
  - Next state is DONE if `in_amt`==0, else SHIFT.
- SHIFT:
  - Each cycle: `data_q` ← shifter(`data_q`, `op_q`) and `cnt_q` ← `cnt_q`−1.
  - When `cnt_q`==1 this cycle, the final step is taken and next state is DONE.
  - `in_valid` is ignored.
- DONE:
  - `out_valid`=1 and `out_data`=`data_q`, both held stable until `out_ready`.
  - On `out_ready`, next state is IDLE.
- `out_data` equals `data_q` in all states. Consumers sample it only when `out_valid`=1.
- Width rules:
  - Logical shifts fill with 0.
  - Rotates move the vacated bit to the opposite end.
  - `cnt_q` never underflows, because SHIFT is only entered with `cnt_q`≥1.
- No overlap: a new request is never accepted while a result is pending, even when `out_ready` is high in DONE. Accept resumes the cycle after return to IDLE.
- Reset mid-operation: the in-flight request is dropped, with no partial result and no `out_valid`. The FSM restarts in IDLE.
- Op changes on `in_op` after acceptance have no effect, because `op_q` is used.

## Timing
- Accept edge: `in_valid`&`in_ready` sampled high at rising edge T0.
- `in_amt`=0: `out_valid` high from T0+1, data unchanged.
- `in_amt`=N (1..DSIZE-1): `out_valid` high from T0+N+1.
- With `out_ready` held high, throughput is one request per N+2 cycles: accept, N steps, DONE, IDLE.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Reset assertion clears all registers immediately, without waiting for `clk`. Deassertion is assumed to be synchronized upstream.

## Structure
- Shared package `shift_pkg`:
  - op encodings `SH_LSR`=2'b00, `SH_LSL`=2'b01, `SH_ROR`=2'b10, `SH_ROL`=2'b11
  - FSM state enum {IDLE, SHIFT, DONE}
- One sub-module: instantiate the existing one-bit `shifter` (parameters `OPSIZE`, `DSIZE`) with `data_b`=`data_q`, `op`=`op_q`.
- The controller contains only the FSM, the counter and the operand register.

## Test plan
- LSR: `in_data`=16'hA5A5, op 00, amt 3 → `out_valid` at T0+4, `out_data`=16'h14B4.
- ROL: 16'h8001, op 11, amt 4 → `out_data`=16'h0018 at T0+5.
- LSL at maximum amount: 16'hFFFF, op 01, amt 15 → 16'h8000 at T0+16; `busy` high for T0+1..T0+16.
- Zero amount: ROR of 16'h0001, amt 0 → `out_data`=16'h0001 at T0+1; `in_ready` low at T0+1.
- Backpressure: hold `out_ready` low 5 cycles in DONE → `out_valid` and `out_data` stable, `in_ready`=0, a concurrent `in_valid` is not accepted; IDLE is reached one cycle after `out_ready`.
- Mid-operation reset: assert `rst_n` low during SHIFT of amt 10 → all outputs return to reset values immediately; after release, a new request (16'h0F0F, op 10, amt 4 → 16'hF0F0) completes correctly.
